javk_biu: RTL and testbench

JAVK_BIU -- requirements
Module: javk_biu

---
 rtl/javk_biu.sv | 149 ++++++++++++++
 tb/tb_javk_biu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/javk_biu.sv
// javk_biu: single-master bus interface unit with a prefetch queue and a load/store port.
// Define JAVK_BIU_WAIT_EN to honour `ready`; by default every bus cycle completes in one clock.
module javk_biu #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       PFQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addrbus,
    output logic              rw,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_new,
    output logic [ADDR_W-1:0] pc,
    output logic              ifetch_valid,
    output logic [DATA_W-1:0] ifetch_data,
    input  logic              ifetch_ready,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ld_data
);
    localparam int unsigned      PTR_W    = $clog2(PFQ_DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PFQ_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                oe_q, oe_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   ld_q, ld_d;
    logic [DATA_W-1:0]   pfq_q [PFQ_DEPTH];

    logic rdy, done, fetch_done, ls_done, push, pop, ls_hold, decide;

`ifdef JAVK_BIU_WAIT_EN
    assign rdy = ready;
`else
    logic unused_ready;
    assign unused_ready = ready;
    assign rdy          = 1'b1;
`endif

    assign done       = (state_q != S_IDLE) && rdy;
    assign fetch_done = (state_q == S_FETCH) && done;
    assign ls_done    = ((state_q == S_LOAD) || (state_q == S_STORE)) && done;
    assign push       = fetch_done && !pc_load;
    assign pop        = (cnt_q != '0) && ifetch_ready && !pc_load;

    assign rd_d  = pc_load ? '0 : rd_q + PTR_W'(pop);
    assign wr_d  = pc_load ? '0 : wr_q + PTR_W'(push);
    assign cnt_d = pc_load ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
    assign pc_d  = pc_load ? pc_new : (fetch_done ? pc_q + ADDR_W'(1) : pc_q);
    assign ack_d = ls_done;
    assign ld_d  = ((state_q == S_LOAD) && done) ? data_in : ld_q;

    // The requester holds ld_req/st_req until it has seen ls_ack, so the request
    // just completed (and the one still visible during the ack cycle) must not restart.
    assign ls_hold = ack_q || ls_done;
    // A redirected fetch is dropped and the next cycle chosen at once, keeping pc_load zero-wait.
    assign decide  = (state_q == S_IDLE) || done || ((state_q == S_FETCH) && pc_load);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        if (decide) begin
            state_d = S_IDLE;
            addr_d  = '0;
            rw_d    = 1'b0;
            dout_d  = '0;
            oe_d    = 1'b0;
            if (st_req && !ls_hold) begin
                state_d = S_STORE;
                addr_d  = ls_addr;
                rw_d    = 1'b1;
                dout_d  = st_data;
                oe_d    = 1'b1;
            end else if (ld_req && !ls_hold) begin
                state_d = S_LOAD;
                addr_d  = ls_addr;
            end else if (cnt_d < FULL_CNT) begin
                state_d = S_FETCH;
                addr_d  = pc_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            pc_q    <= RESET_VEC;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            ld_q    <= ld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            pfq_q[wr_q] <= data_in;
        end
    end

    assign addrbus      = addr_q;
    assign rw           = rw_q;
    assign data_out     = dout_q;
    assign data_oe      = oe_q;
    assign pc           = pc_q;
    assign ifetch_valid = (cnt_q != '0);
    assign ifetch_data  = pfq_q[rd_q];
    assign ls_ack       = ack_q;
    assign ld_data      = ld_q;

endmodule

// File: tb/tb_javk_biu.sv
// Directed and randomized bench for javk_biu against a queue-based behavioural model.
module tb_javk_biu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addrbus;
    logic        rw;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;
    logic        ready = 1'b1;
    logic        pc_load = 1'b0;
    logic [15:0] pc_new = '0;
    logic [15:0] pc;
    logic        ifetch_valid;
    logic [7:0]  ifetch_data;
    logic        ifetch_ready = 1'b0;
    logic        ld_req = 1'b0;
    logic        st_req = 1'b0;
    logic [15:0] ls_addr = '0;
    logic [7:0]  st_data = '0;
    logic        ls_ack;
    logic [7:0]  ld_data;

`ifdef JAVK_BIU_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [65536];
    assign data_in = mem[addrbus];

    javk_biu #(.DATA_W(8), .ADDR_W(16), .PFQ_DEPTH(4), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .rst(rst), .addrbus(addrbus), .rw(rw), .data_out(data_out),
        .data_oe(data_oe), .data_in(data_in), .ready(ready), .pc_load(pc_load),
        .pc_new(pc_new), .pc(pc), .ifetch_valid(ifetch_valid), .ifetch_data(ifetch_data),
        .ifetch_ready(ifetch_ready), .ld_req(ld_req), .st_req(st_req), .ls_addr(ls_addr),
        .st_data(st_data), .ls_ack(ls_ack), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: bus activity, fetch queue as a byte queue, memory as the array above.
    typedef enum int {M_IDLE, M_FETCH, M_LOAD, M_STORE} mst_t;
    mst_t        m_st    = M_IDLE;
    logic [15:0] m_addr  = '0;
    logic [15:0] m_pc    = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_ld    = '0;
    bit          m_ack   = 1'b0;
    bit          m_rst   = 1'b0;
    logic [7:0]  mq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_tick();
        bit done, ack, served;
        if (!rst) begin
            m_st = M_IDLE; m_addr = '0; m_pc = 16'h0000; m_wdata = '0;
            m_ld = '0; m_ack = 1'b0; m_rst = 1'b1;
            mq.delete();
            return;
        end
        m_rst = 1'b0;
        done  = (m_st != M_IDLE) && (WAIT_EN ? ready : 1'b1);
        ack   = done && (m_st == M_LOAD || m_st == M_STORE);
        if (done && m_st == M_LOAD) m_ld = mem[m_addr];
        if (pc_load) begin
            mq.delete();
            m_pc = pc_new;
        end else begin
            if (mq.size() > 0 && ifetch_ready) void'(mq.pop_front());
            if (done && m_st == M_FETCH) begin
                mq.push_back(mem[m_addr]);
                m_pc = m_pc + 16'd1;
            end
        end
        served = m_ack || ack;
        if (m_st == M_IDLE || done || (m_st == M_FETCH && pc_load)) begin
            if (st_req && !served) begin
                m_st = M_STORE; m_addr = ls_addr; m_wdata = st_data;
            end else if (ld_req && !served) begin
                m_st = M_LOAD; m_addr = ls_addr;
            end else if (mq.size() < 4) begin
                m_st = M_FETCH; m_addr = m_pc;
            end else begin
                m_st = M_IDLE;
            end
        end
        m_ack = ack;
    endfunction

    task automatic compare_all();
        chk("ifetch_valid", ifetch_valid, mq.size() != 0);
        if (mq.size() != 0) chk("ifetch_data", ifetch_data, mq[0]);
        chk("pc", pc, m_pc);
        chk("ls_ack", ls_ack, m_ack);
        chk("ld_data", ld_data, m_ld);
        chk("rw", rw, m_st == M_STORE);
        chk("data_oe", data_oe, m_st == M_STORE);
        if (m_st != M_IDLE) chk("addrbus", addrbus, m_addr);
        if (m_st == M_STORE) chk("data_out", data_out, m_wdata);
        if (m_rst) begin
            chk("rst_addrbus", addrbus, 16'h0000);
            chk("rst_data_out", data_out, 8'h00);
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, DUT sampled 1ns later.
    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        compare_all();
        if (ls_ack) begin
            ld_req = 1'b0;
            st_req = 1'b0;
        end
    endtask

    initial begin
        int acks;
        bit saw_store;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Reset
        rst = 1'b0;
        step();
        step();
        chk("reset_valid", ifetch_valid, 1'b0);
        chk("reset_pc", pc, 16'h0000);
        chk("reset_ack", ls_ack, 1'b0);

        // Fill the queue from RESET_VEC with no consumer
        rst = 1'b1; ready = 1'b1; ifetch_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fill_addr", addrbus, 32'(i));
        end
        step();
        chk("fill_valid", ifetch_valid, 1'b1);
        chk("fill_pc", pc, 16'h0004);
        step();
        chk("fill_idle_pc", pc, 16'h0004);

        // Drain while refilling: bytes in address order
        chk("stream_head0", ifetch_data, mem[0]);
        ifetch_ready = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("stream_valid", ifetch_valid, 1'b1);
            chk("stream_head", ifetch_data, mem[j]);
        end

        // Store while fetching
        st_req = 1'b1; ls_addr = 16'h1234; st_data = 8'hA5;
        step();
        chk("store_rw", rw, 1'b1);
        chk("store_oe", data_oe, 1'b1);
        chk("store_addr", addrbus, 16'h1234);
        chk("store_data", data_out, 8'hA5);
        step();
        chk("store_ack", ls_ack, 1'b1);
        step();
        chk("store_ack_pulse", ls_ack, 1'b0);
        chk("store_oe_off", data_oe, 1'b0);

        // Redirect during a fetch, wrapping the pc
        pc_load = 1'b1; pc_new = 16'hFFFF;
        step();
        pc_load = 1'b0;
        chk("redir_empty", ifetch_valid, 1'b0);
        chk("redir_addr", addrbus, 16'hFFFF);
        step();
        chk("redir_valid", ifetch_valid, 1'b1);
        chk("redir_data", ifetch_data, mem[16'hFFFF]);
        chk("redir_wrap_addr", addrbus, 16'h0000);
        chk("redir_wrap_pc", pc, 16'h0000);

        // Load and store requested together: store served, one ack
        ld_req = 1'b1; st_req = 1'b1; ls_addr = 16'h0200; st_data = 8'h3C;
        acks = 0; saw_store = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ls_ack) acks++;
            if (rw && addrbus == 16'h0200) saw_store = 1'b1;
        end
        chk("both_acks", acks, 1);
        chk("both_store", saw_store, 1'b1);
        ld_req = 1'b0; st_req = 1'b0;

        // Load, stretched by three wait cycles when wait states are enabled
        ld_req = 1'b1; ls_addr = 16'h0010; ready = 1'b1;
        step();
        chk("load_addr", addrbus, 16'h0010);
        if (WAIT_EN) begin
            for (int k = 0; k < 3; k++) begin
                ready = 1'b0;
                step();
                chk("load_hold_addr", addrbus, 16'h0010);
                chk("load_no_ack", ls_ack, 1'b0);
            end
            ready = 1'b1;
        end
        acks = 0;
        for (int k = 0; k < 4 && acks == 0; k++) begin
            step();
            if (ls_ack) acks++;
        end
        chk("load_ack", acks, 1);
        chk("load_data", ld_data, mem[16'h0010]);

        // Reset in the middle of a load
        ld_req = 1'b1; ls_addr = 16'h0020; ready = 1'b1;
        step();
        if (WAIT_EN) begin
            ready = 1'b0;
            step();
        end
        rst = 1'b0;
        step();
        chk("midrst_ack", ls_ack, 1'b0);
        chk("midrst_valid", ifetch_valid, 1'b0);
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_ld", ld_data, 8'h00);
        chk("midrst_oe", data_oe, 1'b0);
        ld_req = 1'b0;
        step();
        rst = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            ready        = ($urandom % 4) != 0;
            ifetch_ready = $urandom % 2;
            pc_load      = ($urandom % 16) == 0;
            pc_new       = ($urandom % 4 == 0) ? 16'hFFFE : 16'($urandom);
            rst          = ($urandom % 150) != 0;
            if (!ld_req && !st_req) begin
                if ($urandom % 5 == 0) begin
                    int kind;
                    kind    = $urandom % 3;
                    ls_addr = 16'($urandom);
                    st_data = 8'($urandom);
                    ld_req  = (kind != 1);
                    st_req  = (kind != 0);
                end
            end else if ($urandom % 12 == 0) begin
                ld_req = 1'b0;
                st_req = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
